// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blit scheduler.
// Descriptor layout matches the sprite_table word {base, width, height}.
package sprite_pkg;

  localparam int ID_W     = 6;
  localparam int ADDR_W   = 25;
  localparam int DIM_W    = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CRD_W    = DIM_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
  } sprite_desc_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    LOAD,
    RUN,
    DONE
  } blit_state_t;

  // Sums are one bit wider than DIM_W so off-screen wrap is still visible.
  function automatic logic on_screen(
    input logic [CRD_W-1:0] sx,
    input logic [CRD_W-1:0] sy
  );
    return (sx < CRD_W'(SCREEN_W)) &&
           (sy < CRD_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/sprite_blit_scheduler_if.sv
// Request, sprite_table and pixel-read bundle of the blit scheduler.
// master is the scheduler side, slave is game logic / memory side.
interface sprite_blit_scheduler_if #(
  parameter int N_REQ = 4
);
  import sprite_pkg::*;

  logic                   frame_start;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*ID_W-1:0]  req_id;
  logic [N_REQ*DIM_W-1:0] req_x;
  logic [N_REQ*DIM_W-1:0] req_y;
  logic [N_REQ-1:0]       gnt;
  logic [ID_W-1:0]        tbl_id;
  sprite_desc_t           tbl_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DIM_W-1:0]       fb_x;
  logic [DIM_W-1:0]       fb_y;
  logic                   in_bounds;
  logic                   busy;
  logic                   done;

  modport master (
    input  frame_start, req, req_id, req_x, req_y,
    input  tbl_data, rd_ready,
    output gnt, tbl_id, rd_valid, rd_addr,
    output fb_x, fb_y, in_bounds, busy, done
  );

  modport slave (
    output frame_start, req, req_id, req_x, req_y,
    output tbl_data, rd_ready,
    input  gnt, tbl_id, rd_valid, rd_addr,
    input  fb_x, fb_y, in_bounds, busy, done
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
// The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sprite_blit_scheduler.sv
// Round-robin sprite blit scheduler: grants one requester, fetches its
// descriptor and streams row-major pixel reads tagged with screen coords.
module sprite_blit_scheduler
  import sprite_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input logic                      Clk,
  input logic                      Reset_n,
  sprite_blit_scheduler_if.master  bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  blit_state_t       state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win_idx;
  logic [N_REQ-1:0]  win_gnt;
  logic              win_any;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   tbl_id;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DIM_W-1:0]  fb_x;
  logic [DIM_W-1:0]  fb_y;
  logic              in_bounds;
  logic              busy;
  logic              done;

  logic [DIM_W-1:0]  x0;
  logic [DIM_W-1:0]  y0;
  logic [DIM_W-1:0]  wid;
  logic [DIM_W-1:0]  hgt;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic [DIM_W-1:0]  nxt_col;
  logic [DIM_W-1:0]  nxt_row;
  logic              last_col;
  logic              last_row;
  logic [CRD_W-1:0]  sum_x;
  logic [CRD_W-1:0]  sum_y;
  logic              abort;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PW)
  ) u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .grant (win_gnt),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign last_col = (col == wid - DIM_W'(1));
  assign last_row = (row == hgt - DIM_W'(1));
  assign nxt_col  = last_col ? '0 : col + DIM_W'(1);
  assign nxt_row  = last_col ? row + DIM_W'(1) : row;
  assign sum_x    = {1'b0, x0} + {1'b0, nxt_col};
  assign sum_y    = {1'b0, y0} + {1'b0, nxt_row};
  assign abort    = bus.frame_start && (state != IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      tbl_id    <= '0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      fb_x      <= '0;
      fb_y      <= '0;
      in_bounds <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x0        <= '0;
      y0        <= '0;
      wid       <= '0;
      hgt       <= '0;
      col       <= '0;
      row       <= '0;
    end else if (abort) begin
      state    <= IDLE;
      gnt      <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_any) begin
            state  <= LOOKUP;
            busy   <= 1'b1;
            gnt    <= win_gnt;
            tbl_id <= bus.req_id[int'(win_idx)*ID_W +: ID_W];
            x0     <= bus.req_x[int'(win_idx)*DIM_W +: DIM_W];
            y0     <= bus.req_y[int'(win_idx)*DIM_W +: DIM_W];
            rr_ptr <= (win_idx == PW'(N_REQ - 1)) ?
                      '0 : win_idx + PW'(1);
          end
        end
        LOOKUP: state <= LOAD;
        LOAD: begin
          wid       <= bus.tbl_data.width;
          hgt       <= bus.tbl_data.height;
          rd_addr   <= bus.tbl_data.base;
          col       <= '0;
          row       <= '0;
          fb_x      <= x0;
          fb_y      <= y0;
          in_bounds <= on_screen({1'b0, x0}, {1'b0, y0});
          if (bus.tbl_data.width == '0 ||
              bus.tbl_data.height == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= RUN;
            rd_valid <= 1'b1;
          end
        end
        RUN: begin
          if (bus.rd_ready) begin
            rd_addr   <= rd_addr + ADDR_W'(1);
            col       <= nxt_col;
            row       <= nxt_row;
            fb_x      <= sum_x[DIM_W-1:0];
            fb_y      <= sum_y[DIM_W-1:0];
            in_bounds <= on_screen(sum_x, sum_y);
            if (last_col && last_row) begin
              state    <= DONE;
              rd_valid <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.tbl_id    = tbl_id;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_addr   = rd_addr;
  assign bus.fb_x      = fb_x;
  assign bus.fb_y      = fb_y;
  assign bus.in_bounds = in_bounds;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_sprite_blit_scheduler.sv
// Scoreboard bench for sprite_blit_scheduler: directed requests push
// expected grants/beats/done, a negedge monitor pops and compares.
module tb_sprite_blit_scheduler;
  import sprite_pkg::*;

  localparam int N = 4;
  localparam int BIG = 1000000;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DIM_W-1:0]  fx;
    logic [DIM_W-1:0]  fy;
    logic              ib;
  } beat_t;

  typedef struct {
    logic [ID_W-1:0] id;
    bit              beats;
  } done_t;

  logic clk;
  logic Reset_n;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   acc_total;
  int   oob_total;
  int   stall_total;
  int   last_acc;
  bit   stall_mode;
  logic [3:0] pat;

  beat_t          exp_beats[$];
  logic [N-1:0]   exp_gnt[$];
  done_t          exp_done[$];
  beat_t          mb;
  done_t          md;

  sprite_blit_scheduler_if #(.N_REQ(N)) bus();

  sprite_blit_scheduler #(.N_REQ(N)) dut (
    .Clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  function automatic sprite_desc_t lut(input logic [ID_W-1:0] id);
    sprite_desc_t d;
    case (id)
      6'd0:    d = '{base: 25'd307200,   width: 10'd64, height: 10'd48};
      6'd1:    d = '{base: 25'd1000,     width: 10'd16, height: 10'd16};
      6'd2:    d = '{base: 25'd5000,     width: 10'd2,  height: 10'd2};
      6'd3:    d = '{base: 25'd6000,     width: 10'd3,  height: 10'd1};
      6'd5:    d = '{base: 25'd9000,     width: 10'd0,  height: 10'd5};
      6'd13:   d = '{base: 25'd415490,   width: 10'd23, height: 10'd32};
      6'd63:   d = '{base: 25'd33554430, width: 10'd4,  height: 10'd1};
      default: d = '{base: 25'd0,        width: 10'd1,  height: 10'd1};
    endcase
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bus.tbl_data <= lut(bus.tbl_id);

  always @(posedge clk) begin
    #1;
    bus.rd_ready = stall_mode ? pat[cyc[1:0]] : 1'b1;
  end

  // Monitor: every presented beat must match the head of the queue.
  always @(negedge clk) begin
    if (Reset_n) begin
      if (bus.gnt != '0) begin
        if (exp_gnt.size() == 0)
          chk("gnt_unexpected", bus.gnt, 0);
        else
          chk("gnt_order", bus.gnt, exp_gnt.pop_front());
      end
      if (bus.rd_valid) begin
        if (exp_beats.size() == 0) begin
          chk("beat_unexpected", bus.rd_addr, 0);
        end else begin
          mb = exp_beats[0];
          chk("rd_addr", bus.rd_addr, mb.addr);
          chk("fb_x", bus.fb_x, mb.fx);
          chk("fb_y", bus.fb_y, mb.fy);
          chk("in_bounds", bus.in_bounds, mb.ib);
          if (bus.rd_ready) begin
            void'(exp_beats.pop_front());
            acc_total++;
            last_acc = cyc;
            if (!bus.in_bounds) oob_total++;
          end else begin
            stall_total++;
          end
        end
      end
      if (bus.done) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", bus.done, 0);
        end else begin
          md = exp_done.pop_front();
          chk("done_id", bus.tbl_id, md.id);
          if (md.beats) chk("done_latency", cyc, last_acc + 1);
        end
      end
    end
  end

  task automatic push_blit(input int id, input int x, input int y,
                           input int lim, input bit with_done);
    sprite_desc_t d;
    beat_t b;
    done_t e;
    int n;
    d = lut(ID_W'(id));
    n = 0;
    for (int r = 0; r < int'(d.height); r++) begin
      for (int c = 0; c < int'(d.width); c++) begin
        if (n < lim) begin
          b.addr = ADDR_W'(int'(d.base) + r * int'(d.width) + c);
          b.fx = DIM_W'(x + c);
          b.fy = DIM_W'(y + r);
          b.ib = (x + c < SCREEN_W) && (y + r < SCREEN_H);
          exp_beats.push_back(b);
        end
        n++;
      end
    end
    if (with_done) begin
      e.id = ID_W'(id);
      e.beats = (d.width != '0) && (d.height != '0);
      exp_done.push_back(e);
    end
  endtask

  task automatic set_slot(input int i, input int id, input int x,
                          input int y);
    bus.req_id[i*ID_W +: ID_W] = ID_W'(id);
    bus.req_x[i*DIM_W +: DIM_W] = DIM_W'(x);
    bus.req_y[i*DIM_W +: DIM_W] = DIM_W'(y);
  endtask

  task automatic wait_gnt(output logic [N-1:0] g);
    g = '0;
    for (int k = 0; k < 100 && g == '0; k++) begin
      @(negedge clk);
      g = bus.gnt;
    end
    if (g == '0) chk("gnt_timeout", 0, 1);
  endtask

  task automatic issue(input int i, input int id, input int x,
                       input int y, input int lim, input bit with_done,
                       output int c0);
    logic [N-1:0] g;
    push_blit(id, x, y, lim, with_done);
    exp_gnt.push_back(N'(1 << i));
    @(posedge clk);
    #1;
    set_slot(i, id, x, y);
    bus.req[i] = 1'b1;
    c0 = cyc;
    wait_gnt(g);
    bus.req[i] = 1'b0;
    chk("gnt_latency", cyc, c0 + 1);
  endtask

  task automatic wait_valid(input int c0);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.rd_valid;
    end
    chk("first_beat_latency", cyc, c0 + 3);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int k = 0; k < 20000 && !idle; k++) begin
      @(negedge clk);
      idle = !bus.busy;
    end
    chk("blit_completes", idle, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_tbl_id"}, bus.tbl_id, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 0);
    chk({tag, "_fb_x"}, bus.fb_x, 0);
    chk({tag, "_fb_y"}, bus.fb_y, 0);
    chk({tag, "_in_bounds"}, bus.in_bounds, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int a0;
    int o0;
    int s0;
    int nb;
    bit sv;
    logic [N-1:0] g;
    cyc = 0; n_chk = 0; n_fail = 0;
    acc_total = 0; oob_total = 0; stall_total = 0; last_acc = 0;
    stall_mode = 0; pat = 4'b1001;
    Reset_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.req = '0;
    bus.req_id = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst");
    @(posedge clk);
    #1 Reset_n = 1'b1;

    // Round robin from pointer 0 with all four requesting.
    for (int i = 0; i < N; i++) begin
      push_blit(2, i * 100, 0, BIG, 1);
      exp_gnt.push_back(N'(1 << i));
      set_slot(i, 2, i * 100, 0);
    end
    @(posedge clk);
    #1 bus.req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      wait_gnt(g);
      bus.req = bus.req & ~g;
    end
    wait_idle();

    push_blit(3, 5, 5, BIG, 1);
    push_blit(3, 7, 7, BIG, 1);
    exp_gnt.push_back(4'b0001);
    exp_gnt.push_back(4'b0100);
    set_slot(0, 3, 5, 5);
    set_slot(2, 3, 7, 7);
    @(posedge clk);
    #1 bus.req = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      wait_gnt(g);
      bus.req = bus.req & ~g;
    end
    wait_idle();

    // ID0 at (100,200), always ready.
    a0 = acc_total;
    issue(0, 0, 100, 200, BIG, 1, c0);
    wait_valid(c0);
    wait_idle();
    chk("t1_beats", acc_total - a0, 3072);

    // ID13 with ready pattern 1,0,0,1.
    a0 = acc_total;
    s0 = stall_total;
    stall_mode = 1;
    issue(1, 13, 30, 40, BIG, 1, c0);
    wait_idle();
    stall_mode = 0;
    chk("t2_beats", acc_total - a0, 736);
    chk("t2_stalls_seen", (stall_total - s0) > 0, 1);

    // Zero-width sprite.
    issue(2, 5, 0, 0, BIG, 1, c0);
    nb = bus.busy;
    sv = 0;
    repeat (7) begin
      @(negedge clk);
      nb += bus.busy;
      sv |= bus.rd_valid;
    end
    chk("t4_busy_cycles", nb, 3);
    chk("t4_no_valid", sv, 0);

    // Abort while beat 10 of ID1 is presented.
    issue(3, 1, 50, 60, 11, 0, c0);
    wait_valid(c0);
    repeat (10) @(posedge clk);
    #1 bus.frame_start = 1'b1;
    @(posedge clk);
    #1 bus.frame_start = 1'b0;
    @(negedge clk);
    chk("t5_rd_valid_dropped", bus.rd_valid, 0);
    chk("t5_busy_dropped", bus.busy, 0);
    chk("t5_beats_consumed", exp_beats.size(), 0);
    repeat (3) @(negedge clk);

    // Next request served normally; address and fb_x wrap.
    issue(0, 63, 1022, 479, BIG, 1, c0);
    wait_valid(c0);
    wait_idle();

    // ID0 at x=600: columns 40..63 off screen.
    a0 = acc_total;
    o0 = oob_total;
    issue(1, 0, 600, 10, BIG, 1, c0);
    wait_valid(c0);
    wait_idle();
    chk("t6_beats", acc_total - a0, 3072);
    chk("t6_oob_beats", oob_total - o0, 1152);

    // Reset in the middle of a run.
    issue(2, 0, 0, 0, BIG, 1, c0);
    wait_valid(c0);
    repeat (5) @(posedge clk);
    #2 Reset_n = 1'b0;
    #1;
    check_zero("mid_rst");
    exp_beats.delete();
    exp_done.delete();
    @(posedge clk);
    #1 Reset_n = 1'b1;

    // Pointer restarts at 0 after reset.
    push_blit(2, 1, 1, BIG, 1);
    push_blit(3, 2, 2, BIG, 1);
    exp_gnt.push_back(4'b0010);
    exp_gnt.push_back(4'b1000);
    set_slot(1, 2, 1, 1);
    set_slot(3, 3, 2, 2);
    @(posedge clk);
    #1 bus.req = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      wait_gnt(g);
      bus.req = bus.req & ~g;
    end
    wait_idle();
    repeat (3) @(negedge clk);

    chk("q_beats_empty", exp_beats.size(), 0);
    chk("q_gnt_empty", exp_gnt.size(), 0);
    chk("q_done_empty", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
